async_down_counter: RTL and testbench

ASYNC_DOWN_COUNTER -- requirements
Module: async_down_counter

---
 rtl/async_down_counter.sv | 71 +++++++
 tb/tb_async_down_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/async_down_counter.sv
// ---------------------------------------------------------------------------
// async_down_counter
//
// Purpose:
//   Down-counter that produces the classic ripple (asynchronous) down-count
//   sequence, rebuilt as a fully synchronous design. Each bit is a toggle
//   stage clocked by clk. Stage 0 toggles on every edge. Stage i toggles
//   only when all lower bits are zero, which is the moment a ripple counter
//   would borrow into it. No counter bit drives a clock pin.
//
// Parameters:
//   WIDTH       - counter width in bits (2..16)
//   RESET_VALUE - value loaded while rst is high (default all-ones)
//
// Ports:
//   clk   in   single clock; every state change happens on its rising edge
//   rst   in   synchronous active-high reset
//   count out  current counter value, taken straight from the registers
//   zero  out  combinational flag, high while count == 0
//   wrap  out  registered pulse, high for the one cycle after 0 -> all-ones
// ---------------------------------------------------------------------------
module async_down_counter #(
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;

  // low_zero[i] is high when bits [i-1:0] are all zero. low_zero[0] is
  // always high, so stage 0 toggles every cycle. low_zero[WIDTH] is high
  // when the whole counter is zero, which means the next edge wraps.
  logic [WIDTH:0]   low_zero;
  logic [WIDTH-1:0] toggle;

  always_comb begin
    low_zero    = '0;
    low_zero[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      low_zero[i+1] = low_zero[i] & ~count_q[i];
    end
    toggle  = low_zero[WIDTH-1:0];
    count_d = count_q ^ toggle;
    wrap_d  = low_zero[WIDTH];
  end

  // Reset wins over both the decrement and the wrap pulse. Because of that,
  // wrap stays low after reset even when RESET_VALUE is all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_async_down_counter.sv
// ---------------------------------------------------------------------------
// tb_async_down_counter
//
// Self-checking bench for async_down_counter. It uses two instances: one
// with the default parameters (WIDTH=3, reset to 7) and one with WIDTH=4
// and RESET_VALUE=5. Before each clock edge, a driver sets rst and pushes
// the hand-computed {count, zero, wrap} for the state after that edge. For
// each instance, a monitor pops that entry #1 after the edge and compares
// it with the outputs. The monitor also checks on its own that count
// decrements by one modulo 2^WIDTH on every edge where rst was low.
// ---------------------------------------------------------------------------
module tb_async_down_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic [2:0] count_a;
  logic       zero_a;
  logic       wrap_a;

  logic       rst_b = 1'b1;
  logic [3:0] count_b;
  logic       zero_b;
  logic       wrap_b;

  async_down_counter dut_a (
    .clk   (clk),
    .rst   (rst_a),
    .count (count_a),
    .zero  (zero_a),
    .wrap  (wrap_a)
  );

  async_down_counter #(
    .WIDTH       (4),
    .RESET_VALUE (4'd5)
  ) dut_b (
    .clk   (clk),
    .rst   (rst_b),
    .count (count_b),
    .zero  (zero_b),
    .wrap  (wrap_b)
  );

  // ---------------- scoreboard state ----------------
  logic [4:0] exp_a_q[$];  // {count[2:0], zero, wrap}
  logic [5:0] exp_b_q[$];  // {count[3:0], zero, wrap}
  int errors = 0;
  int checks = 0;

  // ---------------- driver tasks ----------------
  // One call covers one clock edge: r is rst at that edge, and c/w are the
  // hand-computed count and wrap after it.
  task automatic v_a(input int r, input int c, input int w);
    logic [2:0] cc;
    @(negedge clk);
    cc    = c[2:0];
    rst_a = r[0];
    exp_a_q.push_back({cc, (cc == 3'd0), w[0]});
  endtask

  task automatic v_b(input int r, input int c, input int w);
    logic [3:0] cc;
    @(negedge clk);
    cc    = c[3:0];
    rst_b = r[0];
    exp_b_q.push_back({cc, (cc == 4'd0), w[0]});
  endtask

  // ---------------- monitors ----------------
  initial begin : mon_a
    logic [4:0] e;
    logic [2:0] prev;
    logic       have_prev;
    logic       r;
    have_prev = 1'b0;
    prev      = '0;
    forever begin
      @(posedge clk);
      r = rst_a;
      #1;
      if (exp_a_q.size() != 0) begin
        e = exp_a_q.pop_front();
        checks++;
        if ({count_a, zero_a, wrap_a} !== e) begin
          errors++;
          $display("FAIL w3_out t=%0t count=%0d zero=%b wrap=%b required count=%0d zero=%b wrap=%b",
                   $time, count_a, zero_a, wrap_a, e[4:2], e[1], e[0]);
        end
        if (have_prev && !r) begin
          checks++;
          if (count_a !== 3'(prev - 3'd1)) begin
            errors++;
            $display("FAIL w3_decrement t=%0t count=%0d required=%0d",
                     $time, count_a, 3'(prev - 3'd1));
          end
        end
        prev      = count_a;
        have_prev = 1'b1;
      end
    end
  end

  initial begin : mon_b
    logic [5:0] e;
    logic [3:0] prev;
    logic       have_prev;
    logic       r;
    have_prev = 1'b0;
    prev      = '0;
    forever begin
      @(posedge clk);
      r = rst_b;
      #1;
      if (exp_b_q.size() != 0) begin
        e = exp_b_q.pop_front();
        checks++;
        if ({count_b, zero_b, wrap_b} !== e) begin
          errors++;
          $display("FAIL w4_out t=%0t count=%0d zero=%b wrap=%b required count=%0d zero=%b wrap=%b",
                   $time, count_b, zero_b, wrap_b, e[5:2], e[1], e[0]);
        end
        if (have_prev && !r) begin
          checks++;
          if (count_b !== 4'(prev - 4'd1)) begin
            errors++;
            $display("FAIL w4_decrement t=%0t count=%0d required=%0d",
                     $time, count_b, 4'(prev - 4'd1));
          end
        end
        prev      = count_b;
        have_prev = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Default instance: two reset edges, then 7 with zero=0 and wrap=0.
    v_a(1, 7, 0); v_a(1, 7, 0);
    // Sixteen edges make two full periods. wrap pulses only on the two 0 -> 7 edges.
    v_a(0, 6, 0); v_a(0, 5, 0); v_a(0, 4, 0); v_a(0, 3, 0);
    v_a(0, 2, 0); v_a(0, 1, 0); v_a(0, 0, 0); v_a(0, 7, 1);
    v_a(0, 6, 0); v_a(0, 5, 0); v_a(0, 4, 0); v_a(0, 3, 0);
    v_a(0, 2, 0); v_a(0, 1, 0); v_a(0, 0, 0); v_a(0, 7, 1);
    // Count down to 3, reset for one edge there, then resume.
    v_a(0, 6, 0); v_a(0, 5, 0); v_a(0, 4, 0); v_a(0, 3, 0);
    v_a(1, 7, 0); v_a(0, 6, 0);
    // Count down to 0 and reset on that edge. Reset overrides the wrap pulse.
    v_a(0, 5, 0); v_a(0, 4, 0); v_a(0, 3, 0); v_a(0, 2, 0);
    v_a(0, 1, 0); v_a(0, 0, 0); v_a(1, 7, 0); v_a(0, 6, 0);
    // Reset held for several edges keeps the count at 7.
    v_a(1, 7, 0); v_a(1, 7, 0); v_a(1, 7, 0); v_a(0, 6, 0); v_a(0, 5, 0);

    // WIDTH=4, RESET_VALUE=5: 5,4,..,0,15,14. wrap is high while count is 15.
    v_b(1, 5, 0); v_b(0, 4, 0); v_b(0, 3, 0); v_b(0, 2, 0);
    v_b(0, 1, 0); v_b(0, 0, 0); v_b(0, 15, 1); v_b(0, 14, 0);
    v_b(0, 13, 0); v_b(1, 5, 0); v_b(0, 4, 0);

    // Bounded drain: every pushed expectation must have been consumed.
    repeat (3) @(negedge clk);
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending_a=%0d pending_b=%0d required=0",
               exp_a_q.size(), exp_b_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit, so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout t=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
